// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: counts rising edges of one synchronised tap over a gate window.
// Edge pulse lags the tap by 3 cycles; done/result appear the cycle after the last gate cycle.
module ro_freq_meter #(
    parameter int CNT_W         = 24,
    parameter int GATE_W        = 20,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              meas_start,
    input  logic              meas_abort,
    input  logic [2:0]        ch_sel,
    input  logic [GATE_W-1:0] gate_len,
    input  logic [4:0]        ro_in,
    output logic              ro_start,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  result,
    output logic              result_valid,
    output logic              overflow,
    output logic              sel_err
);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, SETTLE, GATE, DONE} state_t;

    state_t state_q, state_d;

    logic [4:0]        sync1_q, sync2_q, sync3_q, edge_q;
    logic [2:0]        ch_q, ch_d;
    logic [GATE_W-1:0] len_q, len_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [GATE_W-1:0] gcnt_q, gcnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_next;
    logic              ovf_int_q, ovf_int_d, ovf_next;
    logic              ro_start_q, ro_start_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  result_q, result_d;
    logic              valid_q, valid_d;
    logic              overflow_q, overflow_d;
    logic              sel_err_q, sel_err_d;
    logic [4:0]        ch_mask;
    logic              edge_sel;

    // Two-flop synchroniser per tap, then a registered rising-edge detect.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            edge_q  <= '0;
        end else begin
            sync1_q <= ro_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= sync2_q & ~sync3_q;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            len_q      <= '0;
            settle_q   <= '0;
            gcnt_q     <= '0;
            cnt_q      <= '0;
            ovf_int_q  <= 1'b0;
            ro_start_q <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            len_q      <= len_d;
            settle_q   <= settle_d;
            gcnt_q     <= gcnt_d;
            cnt_q      <= cnt_d;
            ovf_int_q  <= ovf_int_d;
            ro_start_q <= ro_start_d;
            done_q     <= done_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            sel_err_q  <= sel_err_d;
        end
    end

    always_comb begin
        ch_mask  = 5'd1 << ch_q;
        edge_sel = |(edge_q & ch_mask);
        cnt_next = cnt_q;
        ovf_next = ovf_int_q;
        if (edge_sel) begin
            if (cnt_q == CNT_MAX) begin
                ovf_next = 1'b1;
            end else begin
                cnt_next = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        len_d      = len_q;
        settle_d   = settle_q;
        gcnt_d     = gcnt_q;
        cnt_d      = cnt_q;
        ovf_int_d  = ovf_int_q;
        ro_start_d = 1'b0;
        done_d     = 1'b0;
        result_d   = result_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        sel_err_d  = sel_err_q;

        case (state_q)
            IDLE: begin
                if (meas_start) begin
                    valid_d    = 1'b0;
                    overflow_d = 1'b0;
                    if (ch_sel <= 3'd4) begin
                        state_d    = SETTLE;
                        ch_d       = ch_sel;
                        len_d      = gate_len;
                        settle_d   = '0;
                        cnt_d      = '0;
                        ovf_int_d  = 1'b0;
                        ro_start_d = 1'b1;
                        sel_err_d  = 1'b0;
                    end else begin
                        state_d   = DONE;
                        sel_err_d = 1'b1;
                        result_d  = '0;
                        done_d    = 1'b1;
                    end
                end
            end
            SETTLE: begin
                ro_start_d = 1'b1;
                settle_d   = settle_q + SET_W'(1);
                if (settle_q == SET_LAST) begin
                    if (len_q == '0) begin
                        state_d    = DONE;
                        ro_start_d = 1'b0;
                        result_d   = '0;
                        valid_d    = 1'b1;
                        overflow_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        state_d = GATE;
                        gcnt_d  = '0;
                    end
                end
            end
            GATE: begin
                ro_start_d = 1'b1;
                cnt_d      = cnt_next;
                ovf_int_d  = ovf_next;
                gcnt_d     = gcnt_q + GATE_W'(1);
                // The final gate cycle's edge is folded straight into the result.
                if (gcnt_q == len_q - GATE_W'(1)) begin
                    state_d    = DONE;
                    ro_start_d = 1'b0;
                    result_d   = cnt_next;
                    overflow_d = ovf_next;
                    valid_d    = 1'b1;
                    done_d     = 1'b1;
                end
            end
            DONE: begin
                state_d   = IDLE;
                cnt_d     = '0;
                ovf_int_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides any transition; outputs keep the values cleared at start.
        if (state_q != IDLE && meas_abort) begin
            state_d    = IDLE;
            ro_start_d = 1'b0;
            done_d     = 1'b0;
            cnt_d      = '0;
            ovf_int_d  = 1'b0;
            result_d   = result_q;
            valid_d    = valid_q;
            overflow_d = overflow_q;
            sel_err_d  = sel_err_q;
        end
    end

    assign ro_start     = ro_start_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign overflow     = overflow_q;
    assign sel_err      = sel_err_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Scoreboard bench: waveform-based edge-count model feeds an expectation queue popped on each done pulse.
`timescale 1ns/1ps
module tb_ro_freq_meter;
    localparam int CNT_W  = 8;
    localparam int GATE_W = 12;
    localparam int S      = 16;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              meas_start = 1'b0;
    logic              meas_abort = 1'b0;
    logic [2:0]        ch_sel = '0;
    logic [GATE_W-1:0] gate_len = '0;
    logic [4:0]        ro_in;
    logic              ro_start, busy, done, result_valid, overflow, sel_err;
    logic [CNT_W-1:0]  result;

    ro_freq_meter #(.CNT_W(CNT_W), .GATE_W(GATE_W), .SETTLE_CYCLES(S)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .meas_start(meas_start), .meas_abort(meas_abort),
        .ch_sel(ch_sel), .gate_len(gate_len), .ro_in(ro_in), .ro_start(ro_start),
        .busy(busy), .done(done), .result(result), .result_valid(result_valid),
        .overflow(overflow), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int res;
        bit vld;
        bit ovf;
        bit serr;
        int done_cyc;
        int ro_hi;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    bit   have_last;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   ro_cnt;
    int   half[5];
    int   ph[5];

    task automatic check(string name, longint act, longint expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Tap i is a square wave of half-period half[i] cycles (0 = stuck low).
    function automatic bit wave(int ch, int c);
        if (half[ch] == 0 || c < 0) return 1'b0;
        return (((c + ph[ch]) / half[ch]) % 2) == 1;
    endfunction

    function automatic int rises(int ch, int first, int last);
        int n = 0;
        for (int k = first; k <= last; k++)
            if (wave(ch, k) && !wave(ch, k - 1)) n++;
        return n;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Value presented before posedge number cyc.
    always @(negedge clk)
        for (int i = 0; i < 5; i++) ro_in[i] = wave(i, cyc);

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            ro_cnt    = 0;
            have_last = 1'b0;
        end else begin
            if (!busy) ro_cnt = 0;
            else if (ro_start) ro_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", result, e.res);
                    check("result_valid", result_valid, e.vld);
                    check("overflow", overflow, e.ovf);
                    check("sel_err", sel_err, e.serr);
                    check("done_cycle", cyc, e.done_cyc);
                    check("ro_start_cycles", ro_cnt, e.ro_hi);
                    last_exp  = e;
                    have_last = 1'b1;
                end
            end
        end
    end

    task automatic wait_idle(string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) begin
            check({name, "_timeout"}, 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic run_meas(int ch, int len, int abort_at, int mid_at, bit both);
        exp_t e;
        int   s, n;
        @(negedge clk);
        s          = cyc;
        meas_start = 1'b1;
        meas_abort = both;
        ch_sel     = 3'(ch);
        gate_len   = GATE_W'(len);
        if (ch > 4) begin
            e = '{0, 1'b0, 1'b0, 1'b1, s + 1, 0};
        end else if (len == 0) begin
            e = '{0, 1'b1, 1'b0, 1'b0, s + S + 1, S};
        end else begin
            n = rises(ch, s + S - 2, s + S + len - 3);
            e = '{(n > CMAX) ? CMAX : n, 1'b1, n > CMAX, 1'b0, s + S + len + 1, S + len};
        end
        if (abort_at == 0) exp_q.push_back(e);
        @(negedge clk);
        meas_start = 1'b0;
        meas_abort = 1'b0;
        ch_sel     = 3'($urandom_range(0, 7));
        gate_len   = GATE_W'($urandom);
        if (abort_at > 0) begin
            while (cyc < s + abort_at) @(negedge clk);
            meas_abort = 1'b1;
            @(negedge clk);
            meas_abort = 1'b0;
            check("abort_busy", busy, 0);
            check("abort_ro_start", ro_start, 0);
            check("abort_valid", result_valid, 0);
        end else if (mid_at > 0) begin
            while (cyc < s + mid_at) @(negedge clk);
            meas_start = 1'b1;
            @(negedge clk);
            meas_start = 1'b0;
        end
        wait_idle("meas");
        if (abort_at == 0 && have_last) begin
            repeat (3) @(negedge clk);
            check("hold_result", result, last_exp.res);
            check("hold_valid", result_valid, last_exp.vld);
            check("hold_overflow", overflow, last_exp.ovf);
            check("hold_sel_err", sel_err, last_exp.serr);
        end
    endtask

    task automatic check_zero(string tag);
        check({tag, "_ro_start"}, ro_start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_valid"}, result_valid, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_sel_err"}, sel_err, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, r, ch, len, ab, mid;
        for (int i = 0; i < 5; i++) begin
            half[i] = 0;
            ph[i]   = 0;
        end
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic measurement, then channel isolation.
        half[0] = 5;
        run_meas(0, 100, 0, 0, 1'b0);
        half[0] = 0;
        half[3] = 5;
        run_meas(0, 100, 0, 0, 1'b0);
        run_meas(3, 100, 0, 0, 1'b0);
        // Invalid channel.
        run_meas(5, 50, 0, 0, 1'b0);
        // Saturation: 275 edges into an 8-bit counter.
        half[0] = 2;
        run_meas(0, 1100, 0, 0, 1'b0);
        // Abort at gate cycle 40, then a zero-length gate.
        half[1] = 3;
        run_meas(1, 100, S + 41, 0, 1'b0);
        run_meas(1, 0, 0, 0, 1'b0);
        // Start and abort together in IDLE: start wins.
        run_meas(1, 37, 0, 0, 1'b1);

        // Asynchronous reset mid-gate.
        half[2] = 4;
        @(negedge clk);
        s          = cyc;
        meas_start = 1'b1;
        ch_sel     = 3'd2;
        gate_len   = GATE_W'(200);
        @(negedge clk);
        meas_start = 1'b0;
        while (cyc < s + S + 50) @(negedge clk);
        #3 rst = 1'b1;
        exp_q.delete();
        #1 check_zero("async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        // Start pulse during SETTLE must be ignored.
        run_meas(2, 60, 0, 5, 1'b0);

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 5; i++) begin
                half[i] = $urandom_range(0, 7);
                ph[i]   = $urandom_range(0, 15);
            end
            r   = $urandom_range(0, 9);
            ch  = (r < 8) ? (r % 5) : 5 + $urandom_range(0, 2);
            r   = $urandom_range(0, 9);
            len = (r == 0) ? 0 : (r == 1) ? $urandom_range(1000, 1200) : $urandom_range(1, 200);
            ab  = 0;
            mid = 0;
            if (ch <= 4) begin
                if ($urandom_range(0, 4) == 0) ab = $urandom_range(1, S + len);
                else if ($urandom_range(0, 2) == 0) mid = $urandom_range(1, S + len);
            end
            run_meas(ch, len, ab, mid, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
